seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing a single `bcd7seg` decoder. It holds a frame of BCD digits and steps a digit index at a fixed refresh rate. On each step it presents that digit's BCD code to the shared decoder and drives one-hot digit enables, with a dead-time gap between digits to prevent ghosting. New values are accepted through a load strobe and applied only at frame boundaries, so a displayed number never tears.

---
 rtl/seg_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for NDIG common-anode 7-segment
//            digits sharing one BCD decoder. Holds a displayed frame plus a
//            pending shadow copy that is swapped in only at frame boundaries,
//            steps a digit index every REFRESH_DIV cycles and inserts a
//            GAP_CYC dark interval at the end of every slot.
// Ports    : clk, rst_n (sync, active-low)
//            enable     - scan on / dark and parked at digit 0
//            lz_en      - leading-zero suppression
//            load       - one-cycle strobe capturing bcd_in
//            bcd_in     - NDIG packed BCD digits, digit 0 in bits [3:0]
//            dig_bcd    - BCD code for the shared decoder
//            dig_blank  - current digit must be dark
//            an         - digit enables, one-hot when active
//            frame_tick - first drive cycle of digit 0
//            upd_done   - pending data was applied this cycle
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int NDIG          = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GAP_CYC       = 500,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                lz_en,
  input  logic                load,
  input  logic [4*NDIG-1:0]   bcd_in,
  output logic [3:0]          dig_bcd,
  output logic                dig_blank,
  output logic [NDIG-1:0]     an,
  output logic                frame_tick,
  output logic                upd_done
);

  localparam int IDXW = $clog2(NDIG);
  localparam int CNTW = $clog2(REFRESH_DIV);
  localparam logic [CNTW-1:0] DRIVE_LAST = CNTW'(REFRESH_DIV - GAP_CYC - 1);
  localparam logic [CNTW-1:0] SLOT_LAST  = CNTW'(REFRESH_DIV - 1);
  localparam logic            AN_POL     = (AN_ACTIVE_LOW != 0);
  localparam logic [NDIG-1:0] AN_OFF     = {NDIG{AN_POL}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [4*NDIG-1:0] pend;
  logic              pend_v;
  logic [4*NDIG-1:0] disp;
  logic [IDXW-1:0]   idx;
  logic [CNTW-1:0]   cnt;

  // Digit k of a packed frame (mux form keeps index widths exact).
  function automatic logic [3:0] digit_of(input logic [4*NDIG-1:0] d,
                                          input logic [IDXW-1:0]   k);
    logic [3:0] r;
    r = 4'd0;
    for (int j = 0; j < NDIG; j++) begin
      if (k == IDXW'(j)) r = d[4*j +: 4];
    end
    return r;
  endfunction

  // Dark if the code is not a decimal digit, or if it is a leading zero:
  // this digit and every more-significant one are 0. Digit 0 always shows.
  function automatic logic blank_of(input logic [4*NDIG-1:0] d,
                                    input logic [IDXW-1:0]   k,
                                    input logic              lz);
    logic hi_zero;
    hi_zero = 1'b1;
    for (int j = 0; j < NDIG; j++) begin
      if (IDXW'(j) >= k && d[4*j +: 4] != 4'd0) hi_zero = 1'b0;
    end
    return (digit_of(d, k) > 4'd9) || (lz && (k != '0) && hi_zero);
  endfunction

  function automatic logic [NDIG-1:0] an_of(input logic [IDXW-1:0] k);
    logic [NDIG-1:0] v;
    for (int j = 0; j < NDIG; j++) begin
      v[j] = (k == IDXW'(j)) ^ AN_POL;
    end
    return v;
  endfunction

  // Values for the digit about to be entered. Entry from IDLE and the wrap
  // past the last digit are both frame starts, where pending data (if any)
  // becomes the frame, so the first drive cycle already shows new data.
  logic              step;
  logic              frame_wrap;
  logic [IDXW-1:0]   ent_idx;
  logic [4*NDIG-1:0] ent_disp;

  always_comb begin
    frame_wrap = (state == IDLE) || (idx == IDXW'(NDIG - 1));
    ent_idx    = frame_wrap ? '0 : idx + 1'b1;
    ent_disp   = (frame_wrap && pend_v) ? pend : disp;
    step       = !(state == DRIVE || state == GAP)
               || (state == DRIVE && cnt == DRIVE_LAST && GAP_CYC == 0)
               || (state == GAP   && cnt == SLOT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend       <= '0;
      pend_v     <= 1'b0;
      disp       <= '0;
      idx        <= '0;
      cnt        <= '0;
      an         <= AN_OFF;
      dig_bcd    <= 4'd0;
      dig_blank  <= 1'b1;
      frame_tick <= 1'b0;
      upd_done   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      upd_done   <= 1'b0;

      if (load) begin
        pend   <= bcd_in;
        pend_v <= 1'b1;
      end

      if (!enable) begin
        state     <= IDLE;
        idx       <= '0;
        cnt       <= '0;
        an        <= AN_OFF;
        dig_bcd   <= 4'd0;
        dig_blank <= 1'b1;
      end else if (step) begin
        state     <= DRIVE;
        idx       <= ent_idx;
        cnt       <= '0;
        an        <= an_of(ent_idx);
        dig_bcd   <= digit_of(ent_disp, ent_idx);
        dig_blank <= blank_of(ent_disp, ent_idx, lz_en);
        if (frame_wrap) begin
          frame_tick <= 1'b1;
          if (pend_v) begin
            disp     <= pend;
            upd_done <= 1'b1;
            // A load on this same edge leaves its data pending.
            if (!load) pend_v <= 1'b0;
          end
        end
      end else begin
        cnt       <= cnt + 1'b1;
        dig_blank <= blank_of(disp, idx, lz_en);
        if (state == DRIVE && cnt == DRIVE_LAST) begin
          state <= GAP;
          an    <= AN_OFF;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl. A frame-time reference
//            model (cycle position within the frame, digit = t / slot,
//            phase = t % slot) predicts every output each cycle; scenario
//            tasks add directed checks on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int RD    = 8;
  localparam int GAP   = 2;
  localparam int FRAME = NDIG * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic [3:0]  dig_bcd;
  logic        dig_blank;
  logic [3:0]  an;
  logic        frame_tick;
  logic        upd_done;

  seg_scan_ctrl #(
    .NDIG(NDIG), .REFRESH_DIV(RD), .GAP_CYC(GAP), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lz_en(lz_en), .load(load),
    .bcd_in(bcd_in), .dig_bcd(dig_bcd), .dig_blank(dig_blank), .an(an),
    .frame_tick(frame_tick), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: t = cycle within the frame, -1 when dark/idle.
  int          t = -1;
  logic [15:0] m_pend = 16'h0;
  logic [15:0] m_disp = 16'h0;
  logic        m_pv = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [3:0]  e_bcd = 4'h0;
  logic        e_blank = 1'b1;
  logic        e_ft = 1'b0;
  logic        e_upd = 1'b0;

  logic [8:0] got;
  logic [8:0] exp_v;
  assign got   = {an, dig_bcd, dig_blank, frame_tick, upd_done};
  assign exp_v = {e_an, e_bcd, e_blank, e_ft, e_upd};

  `define MODEL_CHK(tag) begin n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL %s t=%0d: got %h expected %h", tag, t, got, exp_v); end end

  function automatic logic m_blank(logic [15:0] d, int k, logic lz);
    logic [3:0]  v;
    logic [15:0] hi;
    hi = d >> (4 * k);
    v  = hi[3:0];
    return (v > 4'd9) || (lz && k != 0 && hi == 16'h0);
  endfunction

  // One clock edge, then advance the model with the inputs seen at that edge.
  task automatic tick();
    int         dig;
    int         slot;
    logic [15:0] sh;
    @(posedge clk);
    e_ft  = 1'b0;
    e_upd = 1'b0;
    if (!rst_n) begin
      t = -1; m_pend = 16'h0; m_pv = 1'b0; m_disp = 16'h0;
    end else begin
      if (!enable) t = -1;
      else t = (t < 0) ? 0 : (t + 1) % FRAME;
      if (enable && t == 0) begin
        e_ft = 1'b1;
        if (m_pv) begin m_disp = m_pend; m_pv = 1'b0; e_upd = 1'b1; end
      end
      if (load) begin m_pend = bcd_in; m_pv = 1'b1; end
    end
    if (t < 0) begin
      e_an = 4'hF; e_bcd = 4'h0; e_blank = 1'b1;
    end else begin
      dig  = t / RD;
      slot = t % RD;
      e_an = (slot < RD - GAP) ? 4'(~(4'b0001 << dig)) : 4'hF;
      sh   = m_disp >> (4 * dig);
      e_bcd   = sh[3:0];
      e_blank = m_blank(m_disp, dig, lz_en);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; lz_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic adv_to(int target);
    int k = 0;
    while (t != target && k < FRAME + 2) begin
      tick(); `MODEL_CHK("adv_model")
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; load = 1'b0;
    repeat (3) begin
      tick();
      n_cmp++;
      if (an !== 4'hF || dig_blank !== 1'b1 || frame_tick !== 1'b0 || upd_done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: an=%b blank=%b ft=%b upd=%b required 1111 1 0 0", an, dig_blank, frame_tick, upd_done);
      end
    end
    rst_n = 1'b1;
    tick(); `MODEL_CHK("reset_model")
    n_cmp++;
    if (frame_tick !== 1'b1 || an !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_release: ft=%b an=%b required 1 1110", frame_tick, an);
    end
  endtask

  task automatic test_scan_cadence();
    int last_ft;
    do_reset();
    bcd_in = 16'h1234; load = 1'b1; tick(); `MODEL_CHK("cad_load") load = 1'b0;
    enable = 1'b1; tick(); `MODEL_CHK("cad_model")
    n_cmp++;
    if (upd_done !== 1'b1 || dig_bcd !== 4'd4 || an !== 4'b1110) begin
      n_err++;
      $display("FAIL cad_first: upd=%b bcd=%h an=%b required 1 4 1110", upd_done, dig_bcd, an);
    end
    last_ft = 0;
    for (int c = 1; c < 2 * FRAME + 1; c++) begin
      tick(); `MODEL_CHK("cad_model")
      if (frame_tick === 1'b1) begin
        n_cmp++;
        if (c - last_ft !== FRAME) begin
          n_err++;
          $display("FAIL cad_period: got %0d required %0d", c - last_ft, FRAME);
        end
        last_ft = c;
      end
      if (c == 6 || c == 8 || c == 16 || c == 24) begin
        logic [7:0] want;
        case (c)
          6:       want = {4'b1111, dig_bcd};
          8:       want = {4'b1101, 4'd3};
          16:      want = {4'b1011, 4'd2};
          default: want = {4'b0111, 4'd1};
        endcase
        n_cmp++;
        if ({an, dig_bcd} !== want) begin
          n_err++;
          $display("FAIL cad_slot c=%0d: got %h required %h", c, {an, dig_bcd}, want);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    int k;
    k = 0;
    do begin tick(); `MODEL_CHK("tear_model") k++; end while (frame_tick !== 1'b1 && k < 40);
    adv_to(16);
    bcd_in = 16'h5678; load = 1'b1; tick(); `MODEL_CHK("tear_model") load = 1'b0;
    adv_to(18);
    n_cmp++;
    if (an !== 4'b1011 || dig_bcd !== 4'd2) begin
      n_err++; $display("FAIL tear_dig2: an=%b bcd=%h required 1011 2", an, dig_bcd);
    end
    adv_to(24);
    n_cmp++;
    if (an !== 4'b0111 || dig_bcd !== 4'd1) begin
      n_err++; $display("FAIL tear_dig3: an=%b bcd=%h required 0111 1", an, dig_bcd);
    end
    k = 0;
    do begin tick(); `MODEL_CHK("tear_model") k++; end while (frame_tick !== 1'b1 && k < 40);
    n_cmp++;
    if (frame_tick !== 1'b1 || upd_done !== 1'b1 || dig_bcd !== 4'd8) begin
      n_err++; $display("FAIL tear_apply: ft=%b upd=%b bcd=%h required 1 1 8", frame_tick, upd_done, dig_bcd);
    end
    adv_to(3);
    bcd_in = 16'h1111; load = 1'b1; tick(); `MODEL_CHK("tear_model") load = 1'b0;
    adv_to(12);
    bcd_in = 16'h2222; load = 1'b1; tick(); `MODEL_CHK("tear_model") load = 1'b0;
    adv_to(0);
    n_cmp++;
    if (upd_done !== 1'b1 || dig_bcd !== 4'd2) begin
      n_err++; $display("FAIL tear_last_wins: upd=%b bcd=%h required 1 2", upd_done, dig_bcd);
    end
  endtask

  task automatic test_lz_invalid();
    logic [3:0] bl;
    logic [3:0] bc [4];
    logic [15:0] pats [3];
    logic [3:0]  want_bl [3];
    logic [15:0] want_bc [3];
    pats[0] = 16'h0050; want_bl[0] = 4'b1100; want_bc[0] = 16'h0050;
    pats[1] = 16'h0000; want_bl[1] = 4'b1110; want_bc[1] = 16'h0000;
    pats[2] = 16'h0F09; want_bl[2] = 4'b0100; want_bc[2] = 16'h0F09;
    for (int p = 0; p < 3; p++) begin
      do_reset();
      lz_en = (p < 2);
      bcd_in = pats[p]; load = 1'b1; tick(); `MODEL_CHK("lz_model") load = 1'b0;
      enable = 1'b1;
      bl = 4'bxxxx;
      for (int d = 0; d < 4; d++) bc[d] = 4'hx;
      for (int i = 0; i < FRAME; i++) begin
        tick(); `MODEL_CHK("lz_model")
        for (int d = 0; d < 4; d++) begin
          if (an[d] === 1'b0) begin bl[d] = dig_blank; bc[d] = dig_bcd; end
        end
      end
      n_cmp++;
      if (bl !== want_bl[p] || {bc[3], bc[2], bc[1], bc[0]} !== want_bc[p]) begin
        n_err++;
        $display("FAIL lz_blank pat=%h: blank=%b bcd=%h required %b %h", pats[p], bl,
                 {bc[3], bc[2], bc[1], bc[0]}, want_bl[p], want_bc[p]);
      end
    end
  endtask

  task automatic test_disable_collision();
    do_reset();
    bcd_in = 16'h1234; load = 1'b1; tick(); `MODEL_CHK("dis_model") load = 1'b0;
    enable = 1'b1;
    adv_to(17);
    enable = 1'b0; tick(); `MODEL_CHK("dis_model")
    n_cmp++;
    if (an !== 4'hF || dig_blank !== 1'b1) begin
      n_err++; $display("FAIL dis_off: an=%b blank=%b required 1111 1", an, dig_blank);
    end
    bcd_in = 16'h9876; load = 1'b1; tick(); `MODEL_CHK("dis_model") load = 1'b0;
    tick(); `MODEL_CHK("dis_model")
    enable = 1'b1; tick(); `MODEL_CHK("dis_model")
    n_cmp++;
    if (upd_done !== 1'b1 || frame_tick !== 1'b1 || dig_bcd !== 4'd6 || an !== 4'b1110) begin
      n_err++;
      $display("FAIL dis_reenable: upd=%b ft=%b bcd=%h an=%b required 1 1 6 1110", upd_done, frame_tick, dig_bcd, an);
    end
    adv_to(5);
    bcd_in = 16'h4321; load = 1'b1; tick(); `MODEL_CHK("col_model") load = 1'b0;
    adv_to(31);
    bcd_in = 16'h8765; load = 1'b1; tick(); `MODEL_CHK("col_model") load = 1'b0;
    n_cmp++;
    if (upd_done !== 1'b1 || dig_bcd !== 4'd1) begin
      n_err++; $display("FAIL col_old_applied: upd=%b bcd=%h required 1 1", upd_done, dig_bcd);
    end
    adv_to(31);
    tick(); `MODEL_CHK("col_model")
    n_cmp++;
    if (upd_done !== 1'b1 || dig_bcd !== 4'd5) begin
      n_err++; $display("FAIL col_new_pending: upd=%b bcd=%h required 1 5", upd_done, dig_bcd);
    end
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 499) != 0);
      enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      load   = ($urandom_range(0, 23) == 0);
      bcd_in = 16'($urandom) & 16'($urandom | $urandom);
      tick(); `MODEL_CHK("rand_model")
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_cadence();
    test_tear_free();
    test_lz_invalid();
    test_disable_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  `undef MODEL_CHK

endmodule
`default_nettype wire
